// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, keyboard command bytes and default timing.
// Used by the host transmitter and the keyboard receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        DATA      = 3'd3,
        PARITY    = 3'd4,
        STOP      = 3'd5,
        WAIT_IDLE = 3'd6
    } ps2_state_e;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    localparam int DEF_INHIBIT_CYCLES = 15000;
    localparam int DEF_START_TIMEOUT  = 1500000;
    localparam int DEF_XFER_TIMEOUT   = 200000;
    localparam int DEF_FILTER_LEN     = 8;
    localparam int TMO_W              = 21;

    // PS/2 frames carry odd parity: the parity bit makes the count of ones odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 pin conditioning: 2-flop synchronizers on both pins, a glitch filter on
// kclk and a one-cycle strobe on each accepted kclk falling edge.
module ps2_line_sync #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_kclk,
    input  logic i_kdata,
    output logic o_kclk,
    output logic o_kdata,
    output logic o_fall
);

    localparam int CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [1:0]       r_kclk_sync;
    logic [1:0]       r_kdata_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_kclk_f;
    logic             r_kclk_f_d;
    logic             r_fall;

    // Two-stage synchronizers; idle bus level is high on both pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kclk_sync  <= 2'b11;
            r_kdata_sync <= 2'b11;
        end else begin
            r_kclk_sync  <= {r_kclk_sync[0], i_kclk};
            r_kdata_sync <= {r_kdata_sync[0], i_kdata};
        end
    end

    // Accept a kclk level only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= CNT_W'(0);
            r_kclk_f   <= 1'b1;
            r_kclk_f_d <= 1'b1;
            r_fall     <= 1'b0;
        end else begin
            r_kclk_f_d <= r_kclk_f;
            r_fall     <= r_kclk_f_d & ~r_kclk_f;
            if (r_kclk_sync[1] != r_kclk_f) begin
                if (r_cnt == CNT_LAST) begin
                    r_kclk_f <= r_kclk_sync[1];
                    r_cnt    <= CNT_W'(0);
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= CNT_W'(0);
            end
        end
    end

    assign o_kclk  = r_kclk_f;
    assign o_kdata = r_kdata_sync[1];
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, LSB-first data,
// odd parity, stop bit and device acknowledge, with open-drain pin enables.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
    parameter int XFER_TIMEOUT   = DEF_XFER_TIMEOUT,
    parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kclk_in,
    input  logic       kdata_in,
    output logic       kclk_oe,
    output logic       kdata_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy
);

    localparam logic [TMO_W-1:0] INH_LAST   = TMO_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] START_LAST = TMO_W'(START_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] XFER_LAST  = TMO_W'(XFER_TIMEOUT - 1);

    logic w_kclk_s;
    logic w_kdata_s;
    logic w_fall;
    logic w_xfer_exp;

    ps2_state_e       r_state;
    logic [7:0]       r_data;
    logic             r_parity;
    logic [2:0]       r_bit_idx;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [TMO_W-1:0] r_xfer_cnt;
    logic             r_kclk_oe;
    logic             r_kdata_oe;
    logic             r_tx_done;
    logic             r_tx_err;
    logic             r_busy;
    logic             r_tx_ready;

    ps2_line_sync #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_sync (
        .clk     (clk),
        .rst     (rst),
        .i_kclk  (kclk_in),
        .i_kdata (kdata_in),
        .o_kclk  (w_kclk_s),
        .o_kdata (w_kdata_s),
        .o_fall  (w_fall)
    );

    assign w_xfer_exp = (r_xfer_cnt == XFER_LAST);

    // Transfer FSM; every error path releases both lines and returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_data     <= 8'h00;
            r_parity   <= 1'b0;
            r_bit_idx  <= 3'd0;
            r_tmo_cnt  <= TMO_W'(0);
            r_xfer_cnt <= TMO_W'(0);
            r_kclk_oe  <= 1'b0;
            r_kdata_oe <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_err   <= 1'b0;
            r_busy     <= 1'b0;
            r_tx_ready <= 1'b1;
        end else begin
            r_tx_done <= 1'b0;
            r_tx_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tmo_cnt  <= TMO_W'(0);
                    r_xfer_cnt <= TMO_W'(0);
                    r_kdata_oe <= 1'b0;
                    if (tx_valid && r_tx_ready) begin
                        r_data     <= tx_data;
                        r_parity   <= odd_parity(tx_data);
                        r_kclk_oe  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_tx_ready <= 1'b0;
                        r_state    <= INHIBIT;
                    end else begin
                        r_kclk_oe  <= 1'b0;
                        r_busy     <= 1'b0;
                        r_tx_ready <= 1'b1;
                    end
                end
                INHIBIT: begin
                    if (r_tmo_cnt == INH_LAST) begin
                        r_kclk_oe  <= 1'b0;
                        r_kdata_oe <= 1'b1;
                        r_tmo_cnt  <= TMO_W'(0);
                        r_state    <= REQ;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                REQ: begin
                    if (w_fall) begin
                        r_kdata_oe <= ~r_data[0];
                        r_bit_idx  <= 3'd1;
                        r_tmo_cnt  <= TMO_W'(0);
                        r_xfer_cnt <= TMO_W'(0);
                        r_state    <= DATA;
                    end else if (r_tmo_cnt == START_LAST) begin
                        r_kclk_oe  <= 1'b0;
                        r_kdata_oe <= 1'b0;
                        r_tx_err   <= 1'b1;
                        r_busy     <= 1'b0;
                        r_tx_ready <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                DATA: begin
                    if (w_xfer_exp) begin
                        r_kclk_oe  <= 1'b0;
                        r_kdata_oe <= 1'b0;
                        r_tx_err   <= 1'b1;
                        r_busy     <= 1'b0;
                        r_tx_ready <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_xfer_cnt <= r_xfer_cnt + TMO_W'(1);
                        // Bit index wraps to 0 once bit7 is on the wire.
                        if (w_fall) begin
                            if (r_bit_idx == 3'd0) begin
                                r_kdata_oe <= ~r_parity;
                                r_state    <= PARITY;
                            end else begin
                                r_kdata_oe <= ~r_data[r_bit_idx];
                                r_bit_idx  <= r_bit_idx + 3'd1;
                            end
                        end else begin
                            r_kdata_oe <= r_kdata_oe;
                        end
                    end
                end
                PARITY: begin
                    if (w_xfer_exp) begin
                        r_kclk_oe  <= 1'b0;
                        r_kdata_oe <= 1'b0;
                        r_tx_err   <= 1'b1;
                        r_busy     <= 1'b0;
                        r_tx_ready <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_xfer_cnt <= r_xfer_cnt + TMO_W'(1);
                        if (w_fall) begin
                            r_kdata_oe <= 1'b0;
                            r_state    <= STOP;
                        end else begin
                            r_kdata_oe <= r_kdata_oe;
                        end
                    end
                end
                STOP: begin
                    if (w_xfer_exp || (w_fall && w_kdata_s)) begin
                        r_kclk_oe  <= 1'b0;
                        r_kdata_oe <= 1'b0;
                        r_tx_err   <= 1'b1;
                        r_busy     <= 1'b0;
                        r_tx_ready <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_xfer_cnt <= r_xfer_cnt + TMO_W'(1);
                        if (w_fall) begin
                            r_state <= WAIT_IDLE;
                        end else begin
                            r_state <= STOP;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (w_xfer_exp) begin
                        r_kclk_oe  <= 1'b0;
                        r_kdata_oe <= 1'b0;
                        r_tx_err   <= 1'b1;
                        r_busy     <= 1'b0;
                        r_tx_ready <= 1'b1;
                        r_state    <= IDLE;
                    end else if (w_kclk_s && w_kdata_s) begin
                        r_tx_done  <= 1'b1;
                        r_busy     <= 1'b0;
                        r_tx_ready <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_xfer_cnt <= r_xfer_cnt + TMO_W'(1);
                    end
                end
                default: begin
                    r_kclk_oe  <= 1'b0;
                    r_kdata_oe <= 1'b0;
                    r_busy     <= 1'b0;
                    r_tx_ready <= 1'b1;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign kclk_oe  = r_kclk_oe;
    assign kdata_oe = r_kdata_oe;
    assign tx_ready = r_tx_ready;
    assign tx_done  = r_tx_done;
    assign tx_err   = r_tx_err;
    assign busy     = r_busy;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 device model on open-drain pins
// (scaled timing: inhibit 20, start 2000, xfer 4000, filter 2; device clock 40 cycles).
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       kclk_oe, kdata_oe, tx_ready, tx_done, tx_err, busy;
    logic       kclk_pin, kdata_pin;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int busy_rise = 0;
    int err_cyc = 0;
    int rel_cyc = 0;
    bit done_busy_low = 1'b0;
    bit kclk_prev = 1'b0;
    bit busy_prev = 1'b0;

    assign kclk_pin  = ~kclk_oe & dev_clk;
    assign kdata_pin = ~kdata_oe & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES (20),
        .START_TIMEOUT  (2000),
        .XFER_TIMEOUT   (4000),
        .FILTER_LEN     (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .kclk_in  (kclk_pin),
        .kdata_in (kdata_pin),
        .kclk_oe  (kclk_oe),
        .kdata_oe (kdata_oe),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .tx_err   (tx_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor sampled away from the active edge.
    always @(negedge clk) begin
        if (tx_done === 1'b1) begin
            done_cnt      <= done_cnt + 1;
            done_busy_low <= (busy === 1'b0) && (tx_ready === 1'b1);
        end
        if (tx_err === 1'b1) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (kclk_prev && (kclk_oe === 1'b0)) rel_cyc <= cyc;
        kclk_prev <= (kclk_oe === 1'b1);
        if (!busy_prev && (busy === 1'b1)) busy_rise <= busy_rise + 1;
        busy_prev <= (busy === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue a command and act as the device for nclk clock pulses.
    task automatic do_xfer(input logic [7:0] d, input int nclk, input bit ack, input bit hold,
                           output logic [9:0] got, output int inh_len, output bit start_ok);
        got      = 10'h000;
        inh_len  = 0;
        start_ok = 1'b0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
        while ((kclk_oe === 1'b1) && (inh_len < 1000)) begin
            inh_len++;
            @(negedge clk);
        end
        start_ok = (kdata_oe === 1'b1) && (kdata_pin === 1'b0);
        repeat (10) @(negedge clk);
        for (int i = 0; i < nclk; i++) begin
            if ((i == 10) && ack) dev_data = 1'b0;
            dev_clk = 1'b0;
            repeat (20) @(negedge clk);
            dev_clk = 1'b1;
            repeat (15) @(negedge clk);
            if (i < 10) got[i] = kdata_pin;
            repeat (5) @(negedge clk);
            if (i == 10) dev_data = 1'b1;
        end
    endtask

    task automatic wait_end(input int budget, input int d0, input int e0, input bit drop, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((tx_done === 1'b1) || (tx_err === 1'b1) || (done_cnt != d0) || (err_cnt != e0)) begin
                seen = 1'b1;
                if (drop) tx_valid = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (drop) tx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [9:0] got;
        int         inh;
        bit         st_ok;
        bit         seen;
        int         d0, e0, b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_kclk_oe", kclk_oe, 1'b0);
        check("rst_kdata_oe", kdata_oe, 1'b0);
        check("rst_tx_done", tx_done, 1'b0);
        check("rst_tx_err", tx_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b1);

        // 0xED: bits 1,0,1,1,0,1,1,1, parity 1, stop 1
        d0 = done_cnt; e0 = err_cnt;
        @(negedge clk);
        tx_data = 8'hED; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("accept_kclk_oe", kclk_oe, 1'b1);
        check("accept_busy", busy, 1'b1);
        check("accept_ready", tx_ready, 1'b0);
        inh = 0;
        while ((kclk_oe === 1'b1) && (inh < 1000)) begin
            inh++;
            @(negedge clk);
        end
        check("inhibit_len", inh, 20);
        check("start_bit", {kdata_oe, kdata_pin}, 2'b10);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            if (i == 10) dev_data = 1'b0;
            dev_clk = 1'b0;
            repeat (20) @(negedge clk);
            dev_clk = 1'b1;
            repeat (15) @(negedge clk);
            if (i < 10) got[i] = kdata_pin;
            repeat (5) @(negedge clk);
            if (i == 10) dev_data = 1'b1;
        end
        wait_end(200, d0, e0, 1'b0, seen);
        check("ed_end_seen", seen, 1'b1);
        check("ed_data", got[7:0], 8'hED);
        check("ed_parity", got[8], 1'b1);
        check("ed_stop", got[9], 1'b1);
        check("ed_done_cnt", done_cnt - d0, 1);
        check("ed_err_cnt", err_cnt - e0, 0);
        check("ed_busy_with_done", done_busy_low, 1'b1);

        // 0x01 -> parity 0
        d0 = done_cnt; e0 = err_cnt;
        do_xfer(8'h01, 11, 1'b1, 1'b0, got, inh, st_ok);
        wait_end(200, d0, e0, 1'b0, seen);
        check("x01_data", got[7:0], 8'h01);
        check("x01_parity", got[8], 1'b0);
        check("x01_done_cnt", done_cnt - d0, 1);

        // 0x00 -> parity 1
        d0 = done_cnt; e0 = err_cnt;
        do_xfer(8'h00, 11, 1'b1, 1'b0, got, inh, st_ok);
        wait_end(200, d0, e0, 1'b0, seen);
        check("x00_data", got[7:0], 8'h00);
        check("x00_parity", got[8], 1'b1);
        check("x00_stop", got[9], 1'b1);
        check("x00_done_cnt", done_cnt - d0, 1);

        // device never clocks -> start timeout 2000 cycles after kclk release
        d0 = done_cnt; e0 = err_cnt;
        do_xfer(8'hF4, 0, 1'b0, 1'b0, got, inh, st_ok);
        wait_end(3000, d0, e0, 1'b0, seen);
        check("start_to_seen", seen, 1'b1);
        check("start_to_err_cnt", err_cnt - e0, 1);
        check("start_to_delay", err_cyc - rel_cyc, 2000);
        check("start_to_oe", {kclk_oe, kdata_oe}, 2'b00);
        check("start_to_ready", tx_ready, 1'b1);
        check("start_to_no_done", done_cnt - d0, 0);

        // device leaves data high at the ack edge
        d0 = done_cnt; e0 = err_cnt;
        do_xfer(8'hED, 11, 1'b0, 1'b0, got, inh, st_ok);
        wait_end(200, d0, e0, 1'b0, seen);
        check("noack_err_cnt", err_cnt - e0, 1);
        check("noack_no_done", done_cnt - d0, 0);
        check("noack_oe", {kclk_oe, kdata_oe}, 2'b00);

        // device stops clocking after bit 4 -> transfer timeout
        d0 = done_cnt; e0 = err_cnt;
        do_xfer(8'hED, 5, 1'b0, 1'b0, got, inh, st_ok);
        wait_end(5000, d0, e0, 1'b0, seen);
        check("xfer_to_seen", seen, 1'b1);
        check("xfer_to_err_cnt", err_cnt - e0, 1);
        check("xfer_to_no_done", done_cnt - d0, 0);
        check("xfer_to_ready", tx_ready, 1'b1);

        // recovery: 0xFF completes
        d0 = done_cnt; e0 = err_cnt;
        do_xfer(8'hFF, 11, 1'b1, 1'b0, got, inh, st_ok);
        wait_end(200, d0, e0, 1'b0, seen);
        check("xff_start", st_ok, 1'b1);
        check("xff_data", got[7:0], 8'hFF);
        check("xff_parity", got[8], 1'b1);
        check("xff_done_cnt", done_cnt - d0, 1);
        check("xff_err_cnt", err_cnt - e0, 0);

        // tx_valid held high across the whole transfer -> exactly one transfer
        d0 = done_cnt; e0 = err_cnt; b0 = busy_rise;
        do_xfer(8'hF4, 11, 1'b1, 1'b1, got, inh, st_ok);
        wait_end(200, d0, e0, 1'b1, seen);
        repeat (5) @(negedge clk);
        check("hold_data", got[7:0], 8'hF4);
        check("hold_parity", got[8], 1'b0);
        check("hold_done_cnt", done_cnt - d0, 1);
        check("hold_busy_rises", busy_rise - b0, 1);
        check("hold_idle_busy", busy, 1'b0);

        // asynchronous reset in DATA with kdata_oe driven
        d0 = done_cnt; e0 = err_cnt;
        do_xfer(8'h00, 3, 1'b0, 1'b0, got, inh, st_ok);
        check("pre_rst_kdata_oe", kdata_oe, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_oe", {kclk_oe, kdata_oe}, 2'b00);
        check("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_ready", tx_ready, 1'b1);
        check("post_rst_no_err", err_cnt - e0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
